// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset control FSM: sequences fetch/decode/execute/memory/writeback and holds NZCV.
// Latency: 3 to 5+ cycles per instruction; outputs are combinational from the state and instruction fields.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold on mem_ready=0; a bounded wait aborts to FETCH and sets mem_err.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [3:0]            rd,
  input  logic [1:0]            sh,
  input  logic [3:0]            cond,
  input  logic [3:0]            alu_flags,
  input  logic                  mem_ready,
  output logic                  pc_w,
  output logic                  ir_w,
  output logic                  adr_src,
  output logic                  reg_w,
  output logic                  mem_w,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic [1:0]            reg_src,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [3:0]            flags_q,
  output logic                  mem_err,
  output logic [3:0]            state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // Counter only needs to reach MEM_TIMEOUT; keep at least one bit when the timeout is disabled.
  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(MEM_TIMEOUT);

  state_t           state, state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic [3:0]       cmd;
  logic             s_bit;
  logic             i_bit;
  logic             cond_ex;
  logic             wait_st;
  logic             waiting;
  logic             tmo_hit;
  logic             flag_nz_en;
  logic             flag_cv_en;
  logic [2:0]       alu_op3;
  logic             pc_w_raw, ir_w_raw, reg_w_raw, mem_w_raw;

  assign cmd     = funct[4:1];
  assign s_bit   = funct[0];
  assign i_bit   = funct[5];
  assign state_o = state;
  assign imm_src = op;
  assign reg_src = {op == 2'b01, op == 2'b10};

  // Condition code evaluation against the registered flags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Wait detection: a failed-condition store does not wait on memory at all.
  always_comb begin
    wait_st = (state == S_FETCH) || (state == S_MEMREAD) ||
              ((state == S_MEMWRITE) && cond_ex);
    waiting = wait_st && !mem_ready;
    tmo_hit = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == TMO_VAL);
  end

  // ALU operation decode; only the execute/writeback states use the instruction's cmd.
  always_comb begin
    alu_op3 = 3'd0;
    if ((state == S_EXECR) || (state == S_EXECI) || (state == S_ALUWB)) begin
      case (cmd)
        CMD_ADD: alu_op3 = 3'd0;
        CMD_SUB: alu_op3 = 3'd1;
        CMD_AND: alu_op3 = 3'd2;
        CMD_ORR: alu_op3 = 3'd3;
        CMD_CMP: alu_op3 = 3'd1;
        CMD_TST: alu_op3 = 3'd2;
        CMD_MOV: alu_op3 = {1'b1, sh};
        default: alu_op3 = 3'd0;
      endcase
    end
    alu_ctrl = ALU_CTRL_W'(alu_op3);
  end

  // Next-state and datapath controls; enables are squashed during reset and on a timeout abort.
  always_comb begin
    state_d    = S_FETCH;
    pc_w_raw   = 1'b0;
    ir_w_raw   = 1'b0;
    reg_w_raw  = 1'b0;
    mem_w_raw  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    flag_nz_en = 1'b0;
    flag_cv_en = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_w_raw = 1'b1;
          pc_w_raw = 1'b1;
          state_d  = S_DECODE;
        end else begin
          state_d  = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = i_bit ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = s_bit ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w_raw  = cond_ex;
        pc_w_raw   = cond_ex && (rd == 4'd15);
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_w_raw = cond_ex;
        state_d   = (cond_ex && !mem_ready) ? S_MEMWRITE : S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_b  = (state == S_EXECI) ? 2'b01 : 2'b00;
        flag_nz_en = s_bit && cond_ex;
        flag_cv_en = s_bit && cond_ex &&
                     ((cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP));
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w_raw = cond_ex && !((cmd == CMD_CMP) || (cmd == CMD_TST));
        pc_w_raw  = reg_w_raw && (rd == 4'd15);
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_w_raw   = cond_ex;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (tmo_hit) begin
      state_d = S_FETCH;
    end
    pc_w  = pc_w_raw  && rst_n && !tmo_hit;
    ir_w  = ir_w_raw  && rst_n && !tmo_hit;
    reg_w = reg_w_raw && rst_n && !tmo_hit;
    mem_w = mem_w_raw && rst_n && !tmo_hit;
  end

  // State, flags, wait counter and sticky error register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      flags_q  <= 4'b0000;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state <= state_d;
      if (flag_nz_en) flags_q[3:2] <= alu_flags[3:2];
      if (flag_cv_en) flags_q[1:0] <= alu_flags[1:0];
      wait_cnt <= (waiting && !tmo_hit) ? wait_cnt + CNT_W'(1) : '0;
      if (tmo_hit) mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit with a short memory timeout.
// Expected per-cycle controls are queued at drive time and compared on the falling edge.
// Waits are bounded by a global watchdog; the bench never stalls on the DUT.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [1:0] sh;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic       mem_ready;
  logic       pc_w, ir_w, adr_src, reg_w, mem_w;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, reg_src;
  logic [3:0] alu_ctrl;
  logic [3:0] flags_q;
  logic       mem_err;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALU_CTRL_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .rd(rd), .sh(sh),
    .cond(cond), .alu_flags(alu_flags), .mem_ready(mem_ready),
    .pc_w(pc_w), .ir_w(ir_w), .adr_src(adr_src), .reg_w(reg_w), .mem_w(mem_w),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .reg_src(reg_src), .alu_ctrl(alu_ctrl),
    .flags_q(flags_q), .mem_err(mem_err), .state_o(state_o)
  );

  typedef struct {
    logic [3:0] st;
    logic       pc;
    logic       ir;
    logic       rw;
    logic       mw;
    logic [3:0] ac;
    logic [3:0] fl;
    logic       err;
    logic [1:0] op;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
    end
  endtask

  // Datapath selects per state: {adr_src, alu_src_a, alu_src_b, result_src}.
  function automatic logic [6:0] sel_exp(input logic [3:0] s);
    case (s)
      4'd0, 4'd1: sel_exp = {1'b0, 2'b01, 2'b10, 2'b10};
      4'd2:       sel_exp = {1'b0, 2'b00, 2'b01, 2'b00};
      4'd3, 4'd5: sel_exp = {1'b1, 2'b00, 2'b00, 2'b00};
      4'd4:       sel_exp = {1'b0, 2'b00, 2'b00, 2'b01};
      4'd7:       sel_exp = {1'b0, 2'b00, 2'b01, 2'b00};
      4'd9:       sel_exp = {1'b0, 2'b00, 2'b01, 2'b10};
      default:    sel_exp = 7'd0;
    endcase
  endfunction

  // Monitor: pop one expectation per cycle and compare away from the active edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("state",   32'(state_o), 32'(mon_e.st));
      check("pc_w",    32'(pc_w),    32'(mon_e.pc));
      check("ir_w",    32'(ir_w),    32'(mon_e.ir));
      check("reg_w",   32'(reg_w),   32'(mon_e.rw));
      check("mem_w",   32'(mem_w),   32'(mon_e.mw));
      check("alu_ctrl",32'(alu_ctrl),32'(mon_e.ac));
      check("flags_q", 32'(flags_q), 32'(mon_e.fl));
      check("mem_err", 32'(mem_err), 32'(mon_e.err));
      check("selects", 32'({adr_src, alu_src_a, alu_src_b, result_src}), 32'(sel_exp(mon_e.st)));
      check("imm_src", 32'(imm_src), 32'(mon_e.op));
      check("reg_src", 32'(reg_src), 32'({mon_e.op == 2'b01, mon_e.op == 2'b10}));
      cyc_n++;
    end
  end

  task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [1:0] s);
    cond = c; op = o; funct = f; rd = r; sh = s;
  endtask

  // Drive one cycle of inputs and queue the controls expected during that cycle.
  task automatic cyc(input logic mr, input logic [3:0] af, input logic [3:0] st,
                     input logic pc, input logic ir, input logic rw, input logic mw,
                     input logic [3:0] ac, input logic [3:0] fl, input logic err);
    exp_t e;
    mem_ready = mr;
    alu_flags = af;
    e.st = st; e.pc = pc; e.ir = ir; e.rw = rw; e.mw = mw;
    e.ac = ac; e.fl = fl; e.err = err; e.op = op;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=running exp=finished", cyc_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; alu_flags = 4'h0;
    set_instr(4'b1110, 2'b00, 6'b001001, 4'd1, 2'b00);   // ADDS r1
    @(posedge clk); #1;
    cyc(1, 4'h0, 4'd0, 0,0,0,0, 4'd0, 4'h0, 0);          // reset held: enables forced low
    rst_n = 1'b1;
    cyc(1, 4'h0, 4'd0, 1,1,0,0, 4'd0, 4'h0, 0);          // FETCH
    cyc(1, 4'h0, 4'd1, 0,0,0,0, 4'd0, 4'h0, 0);          // DECODE
    cyc(1, 4'h9, 4'd6, 0,0,0,0, 4'd0, 4'h0, 0);          // EXECR, flags from ALU
    cyc(1, 4'h0, 4'd8, 0,0,1,0, 4'd0, 4'h9, 0);          // ALUWB

    set_instr(4'b1110, 2'b01, 6'b011001, 4'd2, 2'b00);   // LDR r2, 3 wait cycles
    cyc(1, 4'h0, 4'd0, 1,1,0,0, 4'd0, 4'h9, 0);
    cyc(1, 4'h0, 4'd1, 0,0,0,0, 4'd0, 4'h9, 0);
    cyc(0, 4'h0, 4'd2, 0,0,0,0, 4'd0, 4'h9, 0);
    for (int i = 0; i < 3; i++) cyc(0, 4'h0, 4'd3, 0,0,0,0, 4'd0, 4'h9, 0);
    cyc(1, 4'h0, 4'd3, 0,0,0,0, 4'd0, 4'h9, 0);
    cyc(1, 4'h0, 4'd4, 0,0,1,0, 4'd0, 4'h9, 0);

    set_instr(4'b0001, 2'b10, 6'b100000, 4'd0, 2'b00);   // BNE, Z=0 -> taken
    cyc(1, 4'h0, 4'd0, 1,1,0,0, 4'd0, 4'h9, 0);
    cyc(1, 4'h0, 4'd1, 0,0,0,0, 4'd0, 4'h9, 0);
    cyc(1, 4'h0, 4'd9, 1,0,0,0, 4'd0, 4'h9, 0);

    set_instr(4'b1110, 2'b00, 6'b111011, 4'd3, 2'b10);   // MOVS r3 ASR, sets Z, keeps CV
    cyc(1, 4'h0, 4'd0, 1,1,0,0, 4'd0, 4'h9, 0);
    cyc(1, 4'h0, 4'd1, 0,0,0,0, 4'd0, 4'h9, 0);
    cyc(1, 4'h4, 4'd7, 0,0,0,0, 4'd6, 4'h9, 0);
    cyc(1, 4'h0, 4'd8, 0,0,1,0, 4'd6, 4'h5, 0);

    set_instr(4'b0001, 2'b10, 6'b100000, 4'd0, 2'b00);   // BNE, Z=1 -> not taken
    cyc(1, 4'h0, 4'd0, 1,1,0,0, 4'd0, 4'h5, 0);
    cyc(1, 4'h0, 4'd1, 0,0,0,0, 4'd0, 4'h5, 0);
    cyc(1, 4'h0, 4'd9, 0,0,0,0, 4'd0, 4'h5, 0);

    set_instr(4'b1110, 2'b00, 6'b010101, 4'd15, 2'b00);  // CMP, rd=15 must not write
    cyc(1, 4'h0, 4'd0, 1,1,0,0, 4'd0, 4'h5, 0);
    cyc(1, 4'h0, 4'd1, 0,0,0,0, 4'd0, 4'h5, 0);
    cyc(1, 4'h2, 4'd6, 0,0,0,0, 4'd1, 4'h5, 0);
    cyc(1, 4'h0, 4'd8, 0,0,0,0, 4'd1, 4'h2, 0);

    set_instr(4'b1110, 2'b00, 6'b000100, 4'd15, 2'b00);  // SUB pc, no S
    cyc(1, 4'h0, 4'd0, 1,1,0,0, 4'd0, 4'h2, 0);
    cyc(1, 4'h0, 4'd1, 0,0,0,0, 4'd0, 4'h2, 0);
    cyc(1, 4'hF, 4'd6, 0,0,0,0, 4'd1, 4'h2, 0);
    cyc(1, 4'h0, 4'd8, 1,0,1,0, 4'd1, 4'h2, 0);

    set_instr(4'b0000, 2'b00, 6'b001001, 4'd4, 2'b00);   // ADDSEQ, condition false
    cyc(1, 4'h0, 4'd0, 1,1,0,0, 4'd0, 4'h2, 0);
    cyc(1, 4'h0, 4'd1, 0,0,0,0, 4'd0, 4'h2, 0);
    cyc(1, 4'hF, 4'd6, 0,0,0,0, 4'd0, 4'h2, 0);
    cyc(1, 4'h0, 4'd8, 0,0,0,0, 4'd0, 4'h2, 0);

    set_instr(4'b0000, 2'b01, 6'b011000, 4'd5, 2'b00);   // STREQ false: no wait
    cyc(1, 4'h0, 4'd0, 1,1,0,0, 4'd0, 4'h2, 0);
    cyc(1, 4'h0, 4'd1, 0,0,0,0, 4'd0, 4'h2, 0);
    cyc(0, 4'h0, 4'd2, 0,0,0,0, 4'd0, 4'h2, 0);
    cyc(0, 4'h0, 4'd5, 0,0,0,0, 4'd0, 4'h2, 0);

    set_instr(4'b1110, 2'b01, 6'b011000, 4'd5, 2'b00);   // STR, ready exactly at the limit
    cyc(1, 4'h0, 4'd0, 1,1,0,0, 4'd0, 4'h2, 0);
    cyc(1, 4'h0, 4'd1, 0,0,0,0, 4'd0, 4'h2, 0);
    cyc(0, 4'h0, 4'd2, 0,0,0,0, 4'd0, 4'h2, 0);
    for (int i = 0; i < 4; i++) cyc(0, 4'h0, 4'd5, 0,0,0,1, 4'd0, 4'h2, 0);
    cyc(1, 4'h0, 4'd5, 0,0,0,1, 4'd0, 4'h2, 0);

    // STR with memory stuck: abort after four wait cycles
    cyc(1, 4'h0, 4'd0, 1,1,0,0, 4'd0, 4'h2, 0);
    cyc(1, 4'h0, 4'd1, 0,0,0,0, 4'd0, 4'h2, 0);
    cyc(0, 4'h0, 4'd2, 0,0,0,0, 4'd0, 4'h2, 0);
    for (int i = 0; i < 4; i++) cyc(0, 4'h0, 4'd5, 0,0,0,1, 4'd0, 4'h2, 0);
    cyc(0, 4'h0, 4'd5, 0,0,0,0, 4'd0, 4'h2, 0);
    cyc(0, 4'h0, 4'd0, 0,0,0,0, 4'd0, 4'h2, 1);
    cyc(0, 4'h0, 4'd0, 0,0,0,0, 4'd0, 4'h2, 1);
    cyc(1, 4'h0, 4'd0, 1,1,0,0, 4'd0, 4'h2, 1);
    rst_n = 1'b0;                                        // reset clears error and flags
    cyc(1, 4'h0, 4'd1, 0,0,0,0, 4'd0, 4'h2, 1);
    cyc(1, 4'h0, 4'd0, 0,0,0,0, 4'd0, 4'h0, 0);
    rst_n = 1'b1;

    set_instr(4'b1110, 2'b11, 6'b000000, 4'd0, 2'b00);   // op=11 NOP
    cyc(1, 4'h0, 4'd0, 1,1,0,0, 4'd0, 4'h0, 0);
    cyc(1, 4'h0, 4'd1, 0,0,0,0, 4'd0, 4'h0, 0);
    cyc(1, 4'h0, 4'd0, 1,1,0,0, 4'd0, 4'h0, 0);

    @(posedge clk); #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle successor to the single-cycle ARM-subset decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Holds the registered NZCV flags and evaluates condition codes internally.
- Stalls on a memory-ready handshake, with a parametrised timeout.
- Drives every datapath enable and mux select of the shared-memory multicycle datapath.

Parameters:
- ALU_CTRL_W, 4, width of alu_ctrl (must be ≥3; upper bits are zero).
- MEM_TIMEOUT, 15, maximum consecutive mem_ready-low wait cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- op  in  2  instr[27:26].
- funct  in  6  instr[25:20] (I, cmd[3:0], S).
- rd  in  4  instr[15:12].
- sh  in  2  instr[6:5].
- cond  in  4  instr[31:28].
- alu_flags  in  4  NZCV from the ALU, current cycle.
- mem_ready  in  1  memory completes the access this cycle.
- pc_w  out  1  PC write enable.
- ir_w  out  1  instruction register write enable.
- adr_src  out  1  0=PC, 1=ALUOut.
- reg_w  out  1  register file write enable.
- mem_w  out  1  memory write enable.
- alu_src_a  out  2  00=reg A, 01=PC.
- alu_src_b  out  2  00=reg B, 01=extended immediate, 10=constant 4.
- result_src  out  2  00=ALUOut, 01=read data, 10=ALU result.
- imm_src  out  2  equals op.
- reg_src  out  2  [0]=(op==10), [1]=(op==01).
- alu_ctrl  out  ALU_CTRL_W  ALU operation.
- flags_q  out  4  registered NZCV.
- mem_err  out  1  sticky timeout error.
- state_o  out  4  current state code (debug).

Behaviour:

Reset and state
- Reset is synchronous and active-low: on a clk edge with rst_n=0, state←FETCH, flags_q←0, wait counter←0, mem_err←0.
- While rst_n=0, pc_w, ir_w, reg_w and mem_w are forced to 0.
- All other outputs are combinational from the state and the instruction fields.
- Default for any output not listed in a state: 0.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Codes 10–15 go to FETCH.

Condition evaluation
- cond_ex is combinational from cond and flags_q: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111→0.

States
- FETCH: adr_src=0, alu_src_a=01, alu_src_b=10, result_src=10.
  - If mem_ready: ir_w=1, pc_w=1, go to DECODE.
  - Otherwise stay in FETCH (wait).
- DECODE: alu_src_a=01, alu_src_b=10, result_src=10. Next state:
  - op=01 → MEMADR.
  - op=00 with funct[5]=0 → EXECR.
  - op=00 with funct[5]=1 → EXECI.
  - op=10 → BRANCH.
  - op=11 → FETCH (NOP).
- MEMADR: alu_src_a=00, alu_src_b=01, ADD. funct[0]=1 → MEMREAD, otherwise MEMWRITE.
- MEMREAD: adr_src=1; wait for mem_ready → MEMWB.
- MEMWB: result_src=01, reg_w=cond_ex (rd==15 also gives pc_w=cond_ex) → FETCH.
- MEMWRITE: adr_src=1, mem_w=cond_ex held until mem_ready → FETCH. If cond_ex=0, go directly to FETCH with no wait.
- EXECR (alu_src_b=00) / EXECI (alu_src_b=01): alu_src_a=00 → ALUWB.
  - If funct[0]&cond_ex: flags_q[3:2]←alu_flags[3:2].
  - For ADD/SUB/CMP, also flags_q[1:0]←alu_flags[1:0].
- ALUWB: result_src=00, reg_w=cond_ex & !(CMP|TST); pc_w=reg_w&(rd==15) → FETCH.
- BRANCH: alu_src_a=00, alu_src_b=01, result_src=10, ADD, pc_w=cond_ex → FETCH.

ALU decode
- Applies in EXECR/EXECI/ALUWB; every other state uses ADD(0).
- cmd ADD 0100→0, SUB 0010→1, AND 0000→2, ORR 1100→3, CMP 1010→1, TST 1000→2.
- MOV 1101→4+sh (4 pass/LSL, 5 LSR, 6 ASR, 7 ROR).
- Any other cmd→0.

Timeout
- Counter increments each cycle in a wait state (FETCH, MEMREAD, MEMWRITE) with mem_ready=0, and clears otherwise.
- When MEM_TIMEOUT≠0 and count reaches MEM_TIMEOUT: mem_err←1, all enables for that cycle are 0, state←FETCH, counter←0.
- mem_err is cleared only by reset.
- If mem_ready=1 in the same cycle the count reaches MEM_TIMEOUT, the access completes and no error is raised.

Test Plan:
1. Reset: hold rst_n=0 two cycles with mem_ready=1 → state_o=0, pc_w=ir_w=0, flags_q=0; release → pc_w=ir_w=1 in cycle 1, state_o=1 next.
2. ADDS r1,r2,r3 (op=00, funct=001001, cond=1110), alu_flags=1001 → states 0,1,6,8,0; flags_q=1001 after EXECR; reg_w=1 in ALUWB; alu_ctrl=0.
3. LDR with mem_ready low 3 cycles in MEMREAD → state_o 3 held 4 cycles, then 4 with reg_w=1, result_src=01.
4. BNE (cond=0001, op=10) with flags_q Z=1 → pc_w=0 in BRANCH; with Z=0 → pc_w=1.
5. MEM_TIMEOUT=4, mem_ready stuck 0 in MEMWRITE → mem_w high 4 cycles, then mem_err=1, state_o=0, mem_err stays 1.
6. CMP (cmd 1010, S=1) → reg_w=0 in ALUWB, alu_ctrl=1, flags updated; MOV with sh=10 → alu_ctrl=6.
